divider_scheduler: RTL and testbench

- Shares one iterative divider core (controller plus datapath) among NREQ requesters.
- Round-robin arbitration accepts one request at a time, with a valid/ready handshake per requester.
- Latches the operands, pulses the core start, waits for core completion with a timeout, then returns quotient/remainder tagged with the requester id.
- Sits between the client blocks and the divider core; it is the only block that drives the core's start and operand inputs.

---
 rtl/divider_scheduler_pkg.sv | 32 +++
 rtl/divider_scheduler_rr_arbiter.sv | 35 +++
 rtl/divider_scheduler.sv | 151 +++++++++++++++
 tb/tb_divider_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_scheduler_pkg
// Description : Shared state encodings, response error codes and index helper
//               for the shared-divider scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    // Modular add for requester indices; step is always below n.
    function automatic int wrap_add(input int base, input int step, input int n);
        int s;
        s = base + step;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first requesting index at or
//               above the pointer, wrapping at NREQ. One-hot grant plus index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import divider_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && i_req[wrap_add(int'(i_ptr), k, NREQ)]) begin
                o_any   = 1'b1;
                o_idx   = IDW'(wrap_add(int'(i_ptr), k, NREQ));
                o_grant[wrap_add(int'(i_ptr), k, NREQ)] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : divider_scheduler
// Description : Round-robin front end sharing one iterative divider core among
//               NREQ requesters; handles divide-by-zero and core timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_scheduler
    import divider_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic                  core_start,
    output logic [WIDTH-1:0]      core_dividend,
    output logic [WIDTH-1:0]      core_divisor,
    input  logic                  core_done,
    input  logic [WIDTH-1:0]      core_quotient,
    input  logic [WIDTH-1:0]      core_remainder,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quotient,
    output logic [WIDTH-1:0]      rsp_remainder,
    output logic [1:0]            rsp_error
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic                 r_core_start;
    logic [WIDTH-1:0]     r_core_dividend;
    logic [WIDTH-1:0]     r_core_divisor;
    logic                 r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_quotient;
    logic [WIDTH-1:0]     r_rsp_remainder;
    logic [1:0]           r_rsp_error;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [NREQ-1:0]      w_grant;
    logic [IDW-1:0]       w_idx;
    logic                 w_any;
    logic [WIDTH-1:0]     w_dividend;
    logic [WIDTH-1:0]     w_divisor;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_dividend = req_dividend[int'(w_idx)*WIDTH +: WIDTH];
    assign w_divisor  = req_divisor[int'(w_idx)*WIDTH +: WIDTH];

    // Ready is masked by reset so it reads zero while reset is asserted.
    assign req_ready = (r_state == S_IDLE && !reset) ? w_grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_id            <= '0;
            r_core_start    <= 1'b0;
            r_core_dividend <= '0;
            r_core_divisor  <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_error     <= ERR_OK;
            r_cnt           <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id            <= w_idx;
                        r_core_dividend <= w_dividend;
                        r_core_divisor  <= w_divisor;
                        if (w_divisor == '0) begin
                            r_rsp_quotient  <= '1;
                            r_rsp_remainder <= w_dividend;
                            r_rsp_error     <= ERR_DIV0;
                            r_rsp_valid     <= 1'b1;
                            r_state         <= S_RESP;
                        end else begin
                            r_core_start <= 1'b1;
                            r_state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    // Count zero is the blanking cycle: done may still show the previous result.
                    if (r_cnt != '0 && core_done) begin
                        r_rsp_quotient  <= core_quotient;
                        r_rsp_remainder <= core_remainder;
                        r_rsp_error     <= ERR_OK;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= S_RESP;
                    end else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        r_rsp_quotient  <= '0;
                        r_rsp_remainder <= '0;
                        r_rsp_error     <= ERR_TMO;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= IDW'(wrap_add(int'(r_id), 1, NREQ));
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_start    = r_core_start;
    assign core_dividend = r_core_dividend;
    assign core_divisor  = r_core_divisor;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_id;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_error     = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_scheduler
// Description : Directed bench for divider_scheduler with a behavioural core,
//               a transaction-level reference model and literal pin checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 31;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic                  core_start;
    logic [WIDTH-1:0]      core_dividend;
    logic [WIDTH-1:0]      core_divisor;
    logic                  core_done = 1'b1;
    logic [WIDTH-1:0]      core_quotient = 8'h5A;
    logic [WIDTH-1:0]      core_remainder = 8'hA5;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]      rsp_remainder;
    logic [1:0]            rsp_error;

    always #5 clk = ~clk;

    divider_scheduler #(
        .NREQ    (NREQ),
        .WIDTH   (WIDTH),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_quotient   (rsp_quotient),
        .rsp_remainder  (rsp_remainder),
        .rsp_error      (rsp_error)
    );

    // ---------------- behavioural divider core ----------------
    int         core_lat   = 10;
    bit         core_hang  = 1'b0;
    bit         core_stale = 1'b0;
    int         c_cnt      = 0;
    bit         c_drop     = 1'b0;
    logic [7:0] c_a, c_b;

    always @(posedge clk) begin
        if (core_start) begin
            c_a   <= core_dividend;
            c_b   <= core_divisor;
            c_cnt <= core_lat;
            if (core_stale) begin
                core_quotient <= 8'hEE;
                c_drop        <= 1'b1;
            end else begin
                core_done <= 1'b0;
            end
        end else begin
            if (c_drop) begin
                core_done <= 1'b0;
                c_drop    <= 1'b0;
            end
            if (c_cnt > 0) begin
                c_cnt <= c_cnt - 1;
                if (c_cnt == 1 && !core_hang) begin
                    core_done      <= 1'b1;
                    core_quotient  <= c_a / c_b;
                    core_remainder <= c_a % c_b;
                end
            end
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [1:0]       e;
        logic             div0;
        logic             hang;
    } exp_t;

    exp_t exq[$];
    exp_t rsp_log[$];
    int   acc_log[$];
    int   m_ptr = 0;
    bit   m_busy = 1'b0;
    int   cyc = 0, acc_cyc = 0, start_cyc = 0;
    int   n_start = 0, n_rdy1 = 0;
    bit   pv = 1'b0, pr = 1'b0;
    logic [19:0] p_rsp;

    // Reference model: plain round-robin over pending requests, arithmetic results.
    always @(negedge clk) begin
        int   g;
        int   a, b;
        exp_t e;
        logic [31:0] exp_ready;
        if (reset) begin
            exq.delete();
            m_busy = 1'b0;
            m_ptr  = 0;
            pv     = 1'b0;
            pr     = 1'b0;
        end else begin
            cyc++;
            if (req_ready[1]) n_rdy1++;
            if (m_busy) begin
                check("ready_while_busy", 32'(req_ready), 0);
            end else begin
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
                exp_ready = (g < 0) ? 32'd0 : (32'd1 << g);
                check("req_ready", 32'(req_ready), exp_ready);
                if (g >= 0) begin
                    a = int'(req_dividend[g*WIDTH +: WIDTH]);
                    b = int'(req_divisor[g*WIDTH +: WIDTH]);
                    e.id   = IDW'(g);
                    e.div0 = (b == 0);
                    e.hang = core_hang;
                    if (b == 0) begin
                        e.q = 8'hFF; e.r = 8'(a); e.e = 2'b01;
                    end else if (core_hang) begin
                        e.q = 8'h00; e.r = 8'h00; e.e = 2'b10;
                    end else begin
                        e.q = 8'(a / b); e.r = 8'(a % b); e.e = 2'b00;
                    end
                    exq.push_back(e);
                    m_busy  = 1'b1;
                    acc_cyc = cyc;
                    acc_log.push_back(g);
                end
            end
            if (core_start) begin
                n_start++;
                start_cyc = cyc;
                check("start_legal", 32'(m_busy && exq.size() > 0 && !exq[0].div0), 1);
            end
            if (rsp_valid && !pv) begin
                if (exq.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else if (exq[0].div0) begin
                    check("rsp_latency_div0", cyc, acc_cyc + 1);
                end else if (exq[0].hang) begin
                    check("rsp_latency_tmo", cyc, start_cyc + TIMEOUT + 1);
                end else begin
                    check("rsp_latency", cyc, start_cyc + core_lat + 2);
                end
            end
            if (rsp_valid && pv && !pr) begin
                check("rsp_hold", 32'({rsp_id, rsp_quotient, rsp_remainder, rsp_error}), 32'(p_rsp));
            end
            if (rsp_valid && rsp_ready && exq.size() > 0) begin
                e = exq.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
                check("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
                check("rsp_error", 32'(rsp_error), 32'(e.e));
                rsp_log.push_back({rsp_id, rsp_quotient, rsp_remainder, rsp_error, 2'b00});
                m_ptr  = (int'(e.id) + 1) % NREQ;
                m_busy = 1'b0;
            end
            pv    = rsp_valid;
            pr    = rsp_ready;
            p_rsp = {rsp_id, rsp_quotient, rsp_remainder, rsp_error};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input int a, input int b);
        req_dividend[i*WIDTH +: WIDTH] = 8'(a);
        req_divisor[i*WIDTH +: WIDTH]  = 8'(b);
        req_valid[i] = 1'b1;
    endtask

    // One cycle of driving: drop req_valid bits that transfer at this edge.
    task automatic step();
        logic [NREQ-1:0] w;
        @(negedge clk);
        w = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~w;
    endtask

    task automatic run(input int maxc);
        int n;
        n = 0;
        forever begin
            step();
            n++;
            if (req_valid == '0 && !m_busy && exq.size() == 0) break;
            if (n >= maxc) begin
                n_chk++;
                n_err++;
                $display("FAIL run_timeout: still busy after %0d cycles, required idle", n);
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_core_start"}, 32'(core_start), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_error"}, 32'(rsp_error), 0);
        check({tag, "_core_ops"}, 32'({core_dividend, core_divisor}), 0);
        check({tag, "_rsp_data"}, 32'({rsp_id, rsp_quotient, rsp_remainder}), 0);
    endtask

    task automatic lit(input string nm, input int idx, input int id, input int q, input int r, input int e);
        exp_t x;
        if (idx >= rsp_log.size()) begin
            check({nm, "_present"}, 0, 1);
        end else begin
            x = rsp_log[idx];
            check({nm, "_id"}, 32'(x.id), id);
            check({nm, "_q"}, 32'(x.q), q);
            check({nm, "_r"}, 32'(x.r), r);
            check({nm, "_err"}, 32'(x.e), e);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        req_valid[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        req_valid = '0;
        reset     = 1'b0;

        // 1: single request 100/7 from requester 1
        rsp_log.delete(); n_start = 0; n_rdy1 = 0;
        set_req(1, 100, 7);
        run(100);
        lit("t1", 0, 1, 14, 2, 0);
        check("t1_start_pulses", n_start, 1);
        check("t1_ready1_pulses", n_rdy1, 1);

        // 2: all four at once from reset, then 1 and 3 together
        do_reset();
        rsp_log.delete(); acc_log.delete();
        set_req(0, 40, 3); set_req(1, 50, 4); set_req(2, 60, 5); set_req(3, 70, 6);
        run(300);
        check("t2_grants", 32'(acc_log.size()), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("t2_grant_order", acc_log[i], i);
        lit("t2a", 0, 0, 13, 1, 0);
        lit("t2b", 1, 1, 12, 2, 0);
        lit("t2c", 2, 2, 12, 0, 0);
        lit("t2d", 3, 3, 11, 4, 0);
        acc_log.delete();
        set_req(1, 9, 4); set_req(3, 15, 4);
        run(200);
        check("t2_next_first", acc_log.size() > 0 ? acc_log[0] : -1, 1);

        // 3: divide by zero, core untouched
        rsp_log.delete(); n_start = 0;
        set_req(2, 55, 0);
        run(50);
        lit("t3", 0, 2, 255, 55, 1);
        check("t3_no_start", n_start, 0);

        // 4: core never completes, then normal service resumes
        rsp_log.delete();
        core_hang = 1'b1;
        set_req(0, 20, 3);
        run(100);
        core_hang = 1'b0;
        set_req(3, 9, 4);
        run(100);
        lit("t4_tmo", 0, 0, 0, 0, 2);
        lit("t4_after", 1, 3, 2, 1, 0);

        // 5: response backpressure with stale done through issue/blanking
        rsp_log.delete();
        core_stale = 1'b1;
        rsp_ready  = 1'b0;
        set_req(1, 200, 9); set_req(2, 30, 7);
        n = 0;
        while (!rsp_valid && n < 60) begin
            step();
            n++;
        end
        check("t5_rsp_seen", 32'(rsp_valid), 1);
        repeat (5) step();
        core_stale = 1'b0;
        rsp_ready  = 1'b1;
        run(200);
        lit("t5a", 0, 1, 22, 2, 0);
        lit("t5b", 1, 2, 4, 2, 0);

        // 6: reset during WAIT, then a fresh 9/2 request
        rsp_log.delete();
        set_req(0, 100, 3);
        n = 0;
        while (!core_start && n < 20) begin
            step();
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        req_valid[2] = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(posedge clk);
        #1;
        req_valid = '0;
        reset     = 1'b0;
        set_req(0, 9, 2);
        run(100);
        lit("t6", 0, 0, 4, 1, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
